serial_six_bit_subtractor: RTL
==============================

Name: serial_six_bit_subtractor

Overview:
- Bit-serial, multi-cycle subtractor; the inverse operation of the team's ripple-carry adder.
- Computes D = A - B - BIN, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Trades latency for area in borrow-chain datapaths.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 6, operand/result width in bits; legal range >= 2.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operands A/B/BIN valid.
- IN_READY  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- BIN  input  1  borrow in.
- OUT_VALID  output  1  result D/BOUT valid.
- OUT_READY  input  1  downstream accepts result.
- D  output  WIDTH  difference, modulo 2^WIDTH.
- BOUT  output  1  borrow out.
- V  output  1  signed overflow flag; see Optional Feature.

Behaviour:
- Reset values (RST_N low, asynchronous):
  - state = IDLE; IN_READY = 1; OUT_VALID = 0; D = 0; BOUT = 0; V = 0.
  - Internal shift registers, borrow register and bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - IN_READY = 1, OUT_VALID = 0.
  - On IN_VALID && IN_READY: latch A, B into shift registers and BIN into the borrow register, set count = 0, go to RUN.
- RUN:
  - IN_READY = 0. Each cycle processes bit a = A_sh[0], b = B_sh[0] with borrow bw.
  - Difference bit d = a ^ b ^ bw; shifted into the result register from the MSB side.
  - Next borrow bw' = (~a & b) | (~(a ^ b) & bw).
  - Operand registers shift right by one; count increments.
  - When count == WIDTH-1: after that edge, load D from the result register, BOUT = bw', update V, go to DONE.
- DONE:
  - OUT_VALID = 1; D, BOUT and V are held stable while OUT_READY = 0.
  - On OUT_READY: go to IDLE.
- Latency: OUT_VALID rises exactly WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum.
- Handshake rules:
  - IN_READY and OUT_VALID are never high together.
  - IN_VALID is ignored outside IDLE; no operand is accepted in the cycle of the result handshake.
  - D/BOUT retain their last value after the result handshake until the next result load; they are meaningful only while OUT_VALID = 1.
- Arithmetic, unsigned view: BOUT = 1 iff A < B + BIN; D = (A - B - BIN) mod 2^WIDTH.
- Boundaries:
  - A = B and BIN = 0 gives D = 0, BOUT = 0.
  - A = 0, B = 0, BIN = 1 wraps to all-ones with BOUT = 1.
- Reset mid-operation: RST_N low in any state aborts immediately to the reset values; the partial result is discarded.

Optional Feature:
- Macro: SUB_OVERFLOW_FLAG_EN.
- Defined: V is registered together with D in DONE.
  - V = (A[WIDTH-1] != B[WIDTH-1]) && (D[WIDTH-1] != A[WIDTH-1]), using the latched operand MSBs (two's-complement overflow of A - B - BIN).
  - V is held with D and cleared by reset.
- Not defined: V is tied to 0; no overflow logic or MSB storage is synthesized.
- Port list is identical in both builds.

Test Plan:
- Basic: A=20, B=7, BIN=0, OUT_READY=1 -> OUT_VALID high exactly 6 cycles after accept, D=13, BOUT=0; IN_READY high again one cycle after the result handshake.
- Borrow out: A=5, B=9, BIN=0 -> D=60 (0x3C), BOUT=1.
- Wrap corners:
  - A=0, B=0, BIN=1 -> D=63, BOUT=1.
  - A=63, B=63, BIN=0 -> D=0, BOUT=0.
  - A=63, B=0, BIN=0 -> D=63, BOUT=0.
- Backpressure: hold OUT_READY=0 for 4 cycles in DONE -> OUT_VALID, D and BOUT unchanged, IN_READY=0; new operands presented with IN_VALID=1 are not accepted; assert OUT_READY -> IDLE, then the new operands are accepted.
- Reset mid-RUN: drop RST_N 3 cycles into an operation -> OUT_VALID=0, D=0, BOUT=0, IN_READY=1 asynchronously; after release, A=10, B=3 -> D=7, BOUT=0.
- Overflow (macro defined): A=31, B=0x3F, BIN=0 -> D=0x20, BOUT=1, V=1; A=10, B=3 -> V=0. Same stimulus with macro undefined -> V=0 throughout, D/BOUT identical.

Source files
------------

// File: rtl/serial_six_bit_subtractor.sv
// serial_six_bit_subtractor
//
// Bit-serial subtractor. It computes D = A - B - BIN one bit per clock, LSB
// first, through a single full-subtractor cell and a registered borrow.
// Operands come in and results go out through valid/ready handshakes.
// OUT_VALID rises exactly WIDTH cycles after the edge that accepts the operands.
//
// Optional build macro: SUB_OVERFLOW_FLAG_EN
//   defined   : v_o is the registered two's-complement overflow of A - B - BIN
//   undefined : v_o is tied to 0, and no MSB storage or overflow logic exists
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operands a_i/b_i/bin_i valid
//   in_ready_o   block can accept operands (IDLE)
//   a_i          minuend, WIDTH bits
//   b_i          subtrahend, WIDTH bits
//   bin_i        borrow in
//   out_valid_o  result d_o/bout_o/v_o valid (DONE)
//   out_ready_i  downstream accepts result
//   d_o          difference modulo 2^WIDTH
//   bout_o       borrow out
//   v_o          signed overflow flag (0 unless SUB_OVERFLOW_FLAG_EN)

module serial_six_bit_subtractor #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o,
    output logic             v_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              bw_q, bw_d;
    logic              bout_q, bout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Full-subtractor cell working on the current LSBs
    logic             a_bit, b_bit, diff_bit, bw_next;
    logic [WIDTH-1:0] res_shift;
    logic             accept, finish;

    assign a_bit     = a_sh_q[0];
    assign b_bit     = b_sh_q[0];
    assign diff_bit  = a_bit ^ b_bit ^ bw_q;
    assign bw_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
    // Difference bits enter from the MSB side, so after WIDTH steps bit 0 of
    // the result sits at bit 0.
    assign res_shift = {diff_bit, res_q[WIDTH-1:1]};

    assign accept = (state_q == StIdle) && in_valid_i;
    assign finish = (state_q == StRun) && (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        d_d         = d_q;
        bw_d        = bw_q;
        bout_d      = bout_q;
        cnt_d       = cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (accept) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    bw_d    = bin_i;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                bw_d   = bw_next;
                res_d  = res_shift;
                cnt_d  = cnt_q + 1'b1;
                if (finish) begin
                    d_d     = res_shift;
                    bout_d  = bw_next;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                // No accept in the result-handshake cycle: IDLE is entered first.
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            bw_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bw_q    <= bw_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d_o    = d_q;
    assign bout_o = bout_q;

`ifdef SUB_OVERFLOW_FLAG_EN
    // The operand shift registers lose their MSBs during RUN, so the sign
    // bits are kept separately for the overflow decision.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic v_q, v_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        v_d     = v_q;
        if (accept) begin
            a_msb_d = a_i[WIDTH-1];
            b_msb_d = b_i[WIDTH-1];
        end
        if (finish) begin
            // diff_bit on the last step is the result MSB.
            v_d = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            v_q     <= v_d;
        end
    end

    assign v_o = v_q;
`else
    assign v_o = 1'b0;
`endif

endmodule
